// File: rtl/mem_load_stage.sv
// mem_load_stage: memory stage of an in-order pipeline. Holds one instruction,
// waits for its data-bus response when a request was issued, aligns load data
// and hands the result to writeback. Responses belonging to flushed requests
// are counted and silently dropped when they come back.
// Optional feature: define MS_UNALIGNED_LOAD_EN to add lwl/lwr merging.
module mem_load_stage #(
    parameter int ES_BUS_WD = 77,
    parameter int WS_BUS_WD = 73,
    parameter int CANCEL_W  = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ws_allowin,
    output logic                 ms_allowin,
    input  logic                 es_to_ms_valid,
    input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
    output logic                 ms_to_ws_valid,
    output logic [WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                 data_data_ok,
    input  logic [31:0]          data_rdata,
    input  logic                 ms_flush,
    output logic                 ms_fwd_valid,
    output logic [4:0]           ms_fwd_dest,
    output logic [31:0]          ms_fwd_data,
    output logic                 ms_fwd_stall
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CANCEL_W-1:0] CANCEL_MAX = {CANCEL_W{1'b1}};

    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
`ifdef MS_UNALIGNED_LOAD_EN
    localparam logic [2:0] OP_LWL = 3'd5;
    localparam logic [2:0] OP_LWR = 3'd6;
`endif

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [CANCEL_W-1:0]  cancel_cnt;
    logic [ES_BUS_WD-1:0] es_bus_p1;
    logic [31:0]          rdata_p1;

    logic        res_from_mem;
    logic        req_issued;
    logic [1:0]  addr_low;
    logic [2:0]  load_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic        accept;
    logic        data_capture;
    logic        data_drop;
    logic        cancel_inc;
    logic        new_req;
    logic [31:0] final_result;
    logic [3:0]  rf_we;

    // Byte/half selection and extension of the returned word; reserved and
    // (when the feature is off) lwl/lwr opcodes fall through to a plain word.
    function automatic logic [31:0] align_load(input logic [2:0]  op,
                                               input logic [1:0]  addr,
                                               input logic [31:0] rdata);
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        logic [31:0] result;
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'b0, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'b0, half_sel};
`ifdef MS_UNALIGNED_LOAD_EN
            OP_LWL: begin
                case (addr)
                    2'd0:    result = {rdata[7:0], 24'b0};
                    2'd1:    result = {rdata[15:0], 16'b0};
                    2'd2:    result = {rdata[23:0], 8'b0};
                    default: result = rdata;
                endcase
            end
            OP_LWR: begin
                case (addr)
                    2'd0:    result = rdata;
                    2'd1:    result = {8'b0, rdata[31:8]};
                    2'd2:    result = {16'b0, rdata[31:16]};
                    default: result = {24'b0, rdata[31:24]};
                endcase
            end
`endif
            default: result = rdata;
        endcase
        return result;
    endfunction

`ifdef MS_UNALIGNED_LOAD_EN
    // Register byte-enables for the partial-word merges.
    function automatic logic [3:0] unaligned_mask(input logic [2:0] op,
                                                  input logic [1:0] addr);
        logic [3:0] mask;
        if (op == OP_LWL) begin
            case (addr)
                2'd0:    mask = 4'b1000;
                2'd1:    mask = 4'b1100;
                2'd2:    mask = 4'b1110;
                default: mask = 4'b1111;
            endcase
        end else begin
            case (addr)
                2'd0:    mask = 4'b1111;
                2'd1:    mask = 4'b0111;
                2'd2:    mask = 4'b0011;
                default: mask = 4'b0001;
            endcase
        end
        return mask;
    endfunction
`endif

    // Saturating up/down update of the outstanding-cancel counter.
    function automatic logic [CANCEL_W-1:0] cancel_update(input logic [CANCEL_W-1:0] cnt,
                                                          input logic inc,
                                                          input logic dec);
        logic [CANCEL_W-1:0] result;
        result = cnt;
        if (dec && !inc) begin
            result = cnt - 1'b1;
        end else if (inc && !dec && cnt != CANCEL_MAX) begin
            result = cnt + 1'b1;
        end
        return result;
    endfunction

    assign {res_from_mem, req_issued, addr_low, load_op, gr_we, dest, alu_result, pc} = es_bus_p1;

    assign new_req      = es_to_ms_bus[75];
    assign ms_allowin   = ((state == ST_EMPTY) || ((state == ST_HOLD) && ws_allowin))
                          && (cancel_cnt == '0);
    assign accept       = es_to_ms_valid && ms_allowin;
    // A response with cancels pending always belongs to a flushed request.
    assign data_drop    = data_data_ok && (cancel_cnt != '0);
    assign data_capture = (state == ST_WAIT) && data_data_ok && (cancel_cnt == '0);
    assign cancel_inc   = ms_flush && (state == ST_WAIT) && !data_data_ok;

    // Next-state selection; a flush overrides everything, including a new accept.
    always_comb begin
        state_next = state;
        if (ms_flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state_next = new_req ? ST_WAIT : ST_HOLD;
                ST_WAIT:  if (data_capture) state_next = ST_HOLD;
                ST_HOLD:  if (ws_allowin) state_next = accept ? (new_req ? ST_WAIT : ST_HOLD)
                                                              : ST_EMPTY;
                default:  state_next = ST_EMPTY;
            endcase
        end
    end

    // Result formation and register-file byte enables for the held instruction.
    always_comb begin
        final_result = res_from_mem ? align_load(load_op, addr_low, rdata_p1) : alu_result;
        rf_we        = gr_we ? 4'b1111 : 4'b0000;
`ifdef MS_UNALIGNED_LOAD_EN
        if (gr_we && res_from_mem && (load_op == OP_LWL || load_op == OP_LWR)) begin
            rf_we = unaligned_mask(load_op, addr_low);
        end
`endif
    end

    // Control state: FSM and outstanding-cancel counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_EMPTY;
            cancel_cnt <= '0;
        end else begin
            state      <= state_next;
            cancel_cnt <= cancel_update(cancel_cnt, cancel_inc, data_drop);
        end
    end

    // Datapath registers: instruction bus and returned word, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            es_bus_p1 <= es_to_ms_bus;
        end
        if (data_capture) begin
            rdata_p1 <= data_rdata;
        end
    end

    assign ms_to_ws_valid = (state == ST_HOLD);
    assign ms_to_ws_bus   = {rf_we, dest, final_result, pc};
    assign ms_fwd_valid   = (state != ST_EMPTY) && gr_we;
    assign ms_fwd_dest    = dest;
    assign ms_fwd_data    = final_result;
    assign ms_fwd_stall   = (state == ST_WAIT) && res_from_mem;

endmodule

// File: doc/mem_load_stage.md
MEM_LOAD_STAGE -- requirements
Module: mem_load_stage

Interface
REQ-001 SHALL have parameter ES_BUS_WD, default 77, width of es_to_ms_bus.
REQ-002 SHALL have parameter WS_BUS_WD, default 73, width of ms_to_ws_bus.
REQ-003 SHALL have parameter CANCEL_W, default 2, width of cancel counter; max pending cancels = 2^CANCEL_W-1.
REQ-004 SHALL have one clock and a synchronous, active-low reset; ports: clk  in  1  clock (all state on rising edge); resetn  in  1  synchronous active-low reset.
REQ-005 SHALL have ports: ws_allowin  in  1  WB accepts; ms_allowin  out  1  MEM accepts.
REQ-006 SHALL have ports: es_to_ms_valid  in  1; es_to_ms_bus  in  ES_BUS_WD  {res_from_mem, req_issued, addr_low[1:0], load_op[2:0], gr_we, dest[4:0], alu_result[31:0], pc[31:0]}, MSB first.
REQ-007 SHALL have ports: ms_to_ws_valid  out  1; ms_to_ws_bus  out  WS_BUS_WD  {rf_we[3:0], dest[4:0], final_result[31:0], pc[31:0]}.
REQ-008 SHALL have ports: data_data_ok  in  1  read/write response; data_rdata  in  32  read data, valid with data_data_ok.
REQ-009 SHALL have ports: ms_flush  in  1  exception/eret flush; ms_fwd_valid  out  1; ms_fwd_dest  out  5; ms_fwd_data  out  32; ms_fwd_stall  out  1  dest produced by an unreturned load.

Function
REQ-010 SHALL use a 3-state FSM: EMPTY, WAIT (req_issued=1, data_ok not yet seen), HOLD (result ready, waiting ws_allowin).
REQ-011 SHALL, on accept (es_to_ms_valid && ms_allowin), latch the bus and go to WAIT if req_issued=1, else HOLD.
REQ-012 SHALL in WAIT, on data_data_ok with cancel_cnt==0, capture data_rdata into a 32-bit buffer and go to HOLD in the same edge.
REQ-013 SHALL assert ms_to_ws_valid only in HOLD; ms_allowin = EMPTY || (HOLD && ws_allowin).
REQ-014 SHALL, in HOLD with ws_allowin and no new accept, go to EMPTY; with a simultaneous accept, go directly to WAIT/HOLD (back-to-back, zero bubble).
REQ-015 SHALL decode load_op: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lwl, 6 lwr, 7 reserved (treated as lw).
REQ-016 SHALL select bytes: lb/lbu byte addr_low, sign/zero-extended (lbu addr 3 -> rdata[31:24]); lh/lhu half addr_low[1].
REQ-017 SHALL set final_result = res_from_mem ? aligned load data : alu_result; rf_we = gr_we ? 4'b1111 : 4'b0000 except lwl/lwr.
REQ-018 SHALL on ms_flush: FSM -> EMPTY next edge, ms_to_ws_valid low; if state was WAIT and data_ok not present that cycle, cancel_cnt++.
REQ-019 SHALL drop each data_data_ok arriving while cancel_cnt>0 and decrement it; drop takes priority over capture.
REQ-020 SHALL hold ms_allowin low while cancel_cnt>0.
REQ-021 SHALL saturate cancel_cnt at max; flush at max SHALL NOT increment (bench-checked illegal).
REQ-022 SHALL drive ms_fwd_valid = state!=EMPTY && gr_we; ms_fwd_dest = dest; ms_fwd_data = final_result; ms_fwd_stall = WAIT && res_from_mem.
REQ-023 SHALL accept data_data_ok in EMPTY/HOLD with cancel_cnt==0 as a protocol error: ignored, no state change.

Reset
REQ-024 SHALL on resetn==0 at clk edge: state EMPTY, cancel_cnt 0, ms_to_ws_valid 0, ms_fwd_valid 0, ms_fwd_stall 0; bus and data buffers need not reset.
REQ-025 SHALL treat reset mid-WAIT as full abort; a later data_ok with cancel_cnt 0 falls under REQ-023.

Configuration
REQ-026 SHALL, with MS_UNALIGNED_LOAD_EN defined, implement lwl (addr 0..3: {rdata[7:0],24'b0}/1000, {rdata[15:0],16'b0}/1100, {rdata[23:0],8'b0}/1110, rdata/1111) and lwr (addr 0..3: rdata/1111, {8'b0,rdata[31:8]}/0111, {16'b0,rdata[31:16]}/0011, {24'b0,rdata[31:24]}/0001).
REQ-027 SHALL, without MS_UNALIGNED_LOAD_EN, treat load_op 5/6 as lw with rf_we 1111 and contain no lwl/lwr logic.

Verification
REQ-028 lb addr_low=3, rdata=0x80FF_0000, data_ok 2 cycles after accept -> WAIT 2 cycles, then final_result 0xFFFF_FF80, rf_we 1111.
REQ-029 Back-to-back non-load ALU ops, ws_allowin=1 -> one result per cycle, ms_allowin never low.
REQ-030 Load in HOLD, ws_allowin=0 for 3 cycles -> ms_to_ws_bus stable, ms_allowin=0, released the cycle ws_allowin=1.
REQ-031 Flush in WAIT, data_ok (rdata 0x1234_5678) 4 cycles later -> cancel_cnt 1 then 0, no ms_to_ws_valid, next load's data captured correctly.
REQ-032 lwr addr_low=2, rdata=0xAABB_CCDD (macro on) -> final_result 0x0000_AABB, rf_we 0011; macro off -> 0xAABB_CCDD, 1111.
REQ-033 resetn low during WAIT -> next cycle all outputs at reset values; stray data_ok ignored.
